// File: rtl/uart_tx_dev.sv
// ---------------------------------------------------------------------------
// uart_tx_dev
//
// UART transmitter peripheral on the processor bridge. Software writes bytes
// into a small FIFO. A four-state FSM sends each byte 8N1 on a registered TX
// line: one start bit, eight data bits LSB first, and one stop bit. Each bit
// lasts a programmable number of clock cycles. A level interrupt is raised
// while the interrupt is enabled and the transmitter has fully drained.
//
// Register map (add_i):
//   0 DATA   : write pushes dat_i[7:0]; reads 0
//   1 STATUS : read {28'b0, ovf, busy, full, empty}; write dat_i[3]=1 clears ovf
//   2 CTRL   : [0] en, [1] ie
//   3 DIV    : [15:0] clock cycles per bit (0 behaves as 1)
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   rst    synchronous active-high reset
//   add_i  register select (device address bits [3:2])
//   we_i   write strobe for this device
//   dat_i  write data
//   dat_o  read data, combinational from add_i and registered state
//   IRQ    level interrupt request (ie && empty && !busy)
//   txd    serial output, registered, idle high
// ---------------------------------------------------------------------------
module uart_tx_dev #(
    parameter int          DEPTH     = 8,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  add_i,
    input  logic        we_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        IRQ,
    output logic        txd
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_e;

    // FIFO storage and bookkeeping
    logic [7:0]    fifoMem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;

    // Control registers
    logic          en_q;
    logic          ie_q;
    logic [15:0]   div_q;

    // Transmitter state
    txState_e      state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bi_q, bi_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;

    logic          empty;
    logic          full;
    logic          busy;
    logic          pop;
    logic          dataWrite;
    logic          push;
    logic          pushDrop;
    logic [15:0]   divEff;
    logic          bitDone;
    logic          unusedBits;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign busy      = (state_q != IDLE);
    assign dataWrite = we_i && (add_i == 2'd0);
    // Fullness is taken before any same-cycle pop, so a push into a full
    // FIFO is always dropped.
    assign push      = dataWrite && !full;
    assign pushDrop  = dataWrite && full;
    assign divEff    = (div_q == 16'd0) ? 16'd1 : div_q;
    // Comparing with >= means a bit still ends if DIV shrinks below the
    // running count in the middle of a bit.
    assign bitDone   = (cnt_q >= (divEff - 16'd1));
    assign unusedBits = ^dat_i[31:16];

    // Next-state and datapath logic for the serialiser
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bi_d    = bi_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_q && !empty) begin
                    pop     = 1'b1;
                    shift_d = fifoMem_q[rdPtr_q];
                    txd_d   = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = START;
                end
            end
            START: begin
                if (bitDone) begin
                    txd_d   = shift_q[0];
                    bi_d    = 3'd0;
                    cnt_d   = 16'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bitDone) begin
                    cnt_d = 16'd0;
                    if (bi_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                        bi_d    = bi_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bitDone) begin
                    cnt_d = 16'd0;
                    // Chain straight into the next start bit so that
                    // queued bytes go out with no idle gap.
                    if (en_q && !empty) begin
                        pop     = 1'b1;
                        shift_d = fifoMem_q[rdPtr_q];
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered state, control registers and FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            bi_q    <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            div_q   <= DIV_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bi_q    <= bi_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;

            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            if (pushDrop) begin
                ovf_q <= 1'b1;
            end else if (we_i && (add_i == 2'd1) && dat_i[3]) begin
                ovf_q <= 1'b0;
            end

            if (we_i && (add_i == 2'd2)) begin
                en_q <= dat_i[0];
                ie_q <= dat_i[1];
            end
            if (we_i && (add_i == 2'd3)) begin
                div_q <= dat_i[15:0];
            end
        end
    end

    // FIFO storage needs no reset; only the pointers define its contents
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= dat_i[7:0];
        end
    end

    // Read mux
    always_comb begin
        dat_o = 32'd0;
        case (add_i)
            2'd0:    dat_o = 32'd0;
            2'd1:    dat_o = {28'd0, ovf_q, busy, full, empty};
            2'd2:    dat_o = {30'd0, ie_q, en_q};
            2'd3:    dat_o = {16'd0, div_q};
            default: dat_o = 32'd0;
        endcase
    end

    assign IRQ = ie_q && empty && !busy;
    assign txd = txd_q;

endmodule

// File: doc/uart_tx_dev.md
Name: uart_tx_dev

Overview:
Memory-mapped UART transmitter peripheral on the processor bridge, alongside the timer and the 32-bit I/O ports. It consumes the bridge's device address, write data and per-device write enable. It buffers bytes in a small FIFO, serialises them 8N1 on a registered TX line at a programmable divisor, and raises a level IRQ into the HWInt vector when its queue drains.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64
DIV_RESET, 434, reset value of the DIV register (clock cycles per bit)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
add_i  input  2  register select, driven from device address bits [3:2]
we_i  input  1  write strobe for this device from the bridge
dat_i  input  32  write data
dat_o  output  32  read data, combinational from add_i and registered state
IRQ  output  1  level interrupt request to the bridge
txd  output  1  serial output, registered, idle high

Behaviour:
- Register map (add_i):
  - 0 DATA: write pushes dat_i[7:0]; reads 0.
  - 1 STATUS: read {28'b0, ovf, busy, full, empty}; write with dat_i[3]=1 clears ovf, other bits ignored.
  - 2 CTRL: [0] en, [1] ie, R/W, upper bits read 0.
  - 3 DIV: [15:0] R/W, upper bits read 0.
- Reset (synchronous, overrides everything, including mid-frame): txd=1, state=IDLE, FIFO empty (rd/wr pointers 0, count 0), CTRL=0, DIV=DIV_RESET, ovf=0, IRQ=0. A frame in flight is abandoned immediately.
- Effective divisor D = DIV, or 1 when DIV=0.
- FIFO:
  - Push on we_i && add_i==0.
  - Push while full: byte dropped, ovf<=1 (sticky). Full is evaluated before any same-cycle pop, so a push when full is dropped even if a pop occurs that cycle.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- TX FSM states: IDLE, START, DATA, STOP. Bit counter bi (3 bits), cycle counter cnt (16 bits).
  - IDLE: if en && !empty at a clock edge, pop head into shift register, txd<=0, cnt<=0, go to START. A byte pushed at edge N into an empty FIFO drives txd low at edge N+1.
  - Bit time: each bit is held D cycles; advance when cnt>=D-1, else cnt++.
  - START end: txd<=shift[0], bi<=0, go to DATA.
  - DATA end: if bi==7, txd<=1 and go to STOP; else shift right, txd<=next LSB, bi++.
  - STOP end: if en && !empty, pop and go straight to START (txd<=0); else go to IDLE. Back-to-back frames are exactly 10*D cycles each.
- DIV written mid-frame takes effect at the current bit's comparison (>= prevents hang if cnt already exceeds the new D-1).
- en cleared mid-frame: current frame completes, no new frame starts, FIFO contents retained.
- busy = (state != IDLE).
- IRQ = ie && empty && !busy, combinational from registers. It is 1 on the cycle after ie is set while idle and empty. It is 0 from the edge where a push lands.
- dat_o has no read side effects; reading DATA never pops.

Test Plan:
- Reset, then read all four registers -> DATA=0, STATUS=0x1, CTRL=0, DIV=434; txd=1, IRQ=0.
- DIV=4, CTRL=1, write DATA=0xA5 -> txd low at the next edge for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. Frame = 40 cycles, busy=0 afterwards.
- CTRL=0, DEPTH=8, push 9 bytes 0x00..0x08 -> STATUS=0xA (full, ovf), byte 0x08 lost. Set CTRL=1 -> exactly 8 back-to-back frames, 80*D cycles with no idle gap. Write STATUS=0x8 -> ovf=0.
- CTRL=3 (en, ie) with empty FIFO -> IRQ=1. Push 0x55 -> IRQ=0 from that edge. IRQ returns to 1 on the cycle after the stop bit ends.
- DIV=0 -> D=1, 0x0F frame lasts 10 cycles. Mid-frame write DIV=8 with cnt=0 -> remaining bits last 8 cycles each.
- Assert rst mid-DATA bit -> next cycle txd=1, state IDLE, FIFO empty, IRQ=0. No residual bits after release.
